voice_param_bank: RTL

//  Per-voice parameter store downstream of the SPI note decoder. Captures each

---
 rtl/voice_param_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/voice_param_bank.sv
// Per-voice parameter table fed by decoded note events, scanned out as a valid/ready stream.
// Optional VOICE_COUNT_EN builds a registered count of sounding voices on o_active_voices.
module voice_param_bank #(
  parameter int NUM_VOICES = 16,
  parameter int VOICE_W    = 4,
  parameter int TUNING_W   = 32,
  parameter int VEL_W      = 7
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_SPI_flag,
  input  logic                i_SPI_note_status,
  input  logic [7:0]          i_SPI_voice_index,
  input  logic [TUNING_W-1:0] i_SPI_tuning_code,
  input  logic [VEL_W-1:0]    i_SPI_velocity,
  input  logic                i_voice_ready,
  output logic                o_voice_valid,
  output logic [VOICE_W-1:0]  o_voice_index,
  output logic                o_voice_gate,
  output logic [TUNING_W-1:0] o_voice_tuning,
  output logic [VEL_W-1:0]    o_voice_velocity,
  output logic                o_frame_start,
  output logic [7:0]          o_bad_index_cnt,
  output logic [VOICE_W:0]    o_active_voices
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic                flag_d;
  logic                wr;
  logic                bad;
  logic                wr_ok;
  logic [VOICE_W-1:0]  wr_idx;
  logic [VOICE_W-1:0]  ptr;
  logic [VOICE_W-1:0]  p_next;
  logic                valid;

  logic                gate_tab   [NUM_VOICES];
  logic [TUNING_W-1:0] tuning_tab [NUM_VOICES];
  logic [VEL_W-1:0]    vel_tab    [NUM_VOICES];

  logic                gate_n;
  logic [TUNING_W-1:0] tuning_n;
  logic [VEL_W-1:0]    vel_n;

  // One write per strobe rise; out-of-range slots are counted and dropped.
  assign wr     = i_SPI_flag & ~flag_d;
  assign bad    = {1'b0, i_SPI_voice_index} >= 9'(NUM_VOICES);
  assign wr_ok  = wr & ~bad;
  assign wr_idx = i_SPI_voice_index[VOICE_W-1:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= IDLE;
      flag_d          <= 1'b0;
      o_bad_index_cnt <= '0;
    end else begin
      state  <= state_next;
      flag_d <= i_SPI_flag;
      if (wr && bad && o_bad_index_cnt != 8'hFF)
        o_bad_index_cnt <= o_bad_index_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    valid      = 1'b0;
    case (state)
      IDLE: state_next = RUN;
      RUN:  valid      = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign p_next = (valid & i_voice_ready) ? ptr + 1'b1 : ptr;

  // Bypass so a write to the slot being loaded is visible right after the write edge.
  always_comb begin
    gate_n   = gate_tab[p_next];
    tuning_n = tuning_tab[p_next];
    vel_n    = vel_tab[p_next];
    if (wr_ok && wr_idx == p_next) begin
      gate_n = i_SPI_note_status;
      if (i_SPI_note_status) begin
        tuning_n = i_SPI_tuning_code;
        vel_n    = i_SPI_velocity;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        gate_tab[i]   <= 1'b0;
        tuning_tab[i] <= '0;
        vel_tab[i]    <= '0;
      end
    end else if (wr_ok) begin
      gate_tab[wr_idx] <= i_SPI_note_status;
      if (i_SPI_note_status) begin
        tuning_tab[wr_idx] <= i_SPI_tuning_code;
        vel_tab[wr_idx]    <= i_SPI_velocity;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr              <= '0;
      o_voice_gate     <= 1'b0;
      o_voice_tuning   <= '0;
      o_voice_velocity <= '0;
    end else begin
      ptr              <= p_next;
      o_voice_gate     <= gate_n;
      o_voice_tuning   <= tuning_n;
      o_voice_velocity <= vel_n;
    end
  end

  assign o_voice_valid = valid;
  assign o_voice_index = ptr;
  assign o_frame_start = (ptr == '0) & valid;

`ifdef VOICE_COUNT_EN
  logic [VOICE_W:0] active;

  // Only real gate transitions move the count; retriggers and redundant offs do not.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      active <= '0;
    end else if (wr_ok) begin
      if (i_SPI_note_status && !gate_tab[wr_idx])
        active <= active + 1'b1;
      else if (!i_SPI_note_status && gate_tab[wr_idx])
        active <= active - 1'b1;
    end
  end

  assign o_active_voices = active;
`else
  assign o_active_voices = '0;
`endif

endmodule
